load_align_unit: RTL and testbench
==================================

// Module: load_align_unit
// PURPOSE
// - Sequential load unit between EX/MEM and the data memory port; next generation of the combinational load extractor.
// - Accepts one load request per handshake and issues word-aligned reads. Memory read latency is fixed at 1 cycle.
// - Handles misaligned loads, including ones that cross a word boundary (two beats), and sign/zero-extends to XLEN.
// - Returns a registered response with an error flag; supports a pipeline flush.
// PARAMETERS
// XLEN          32  data width, 32 or 64; 64 adds LD (3'b011) and LWU (3'b110)
// ADDR_W        32  byte-address width
// MISALIGN_EN   1   1: misaligned loads serviced; 0: misaligned loads return err
// PORTS
// clk          in   1        clock, rising edge
// rst_n        in   1        asynchronous active-low reset
// flush        in   1        synchronous kill of the in-flight load
// req_valid    in   1        load request valid
// req_ready    out  1        unit can accept a request (state IDLE)
// req_addr     in   ADDR_W   byte address (ALU result)
// req_funct3   in   3        RISC-V load funct3
// req_rd       in   5        destination tag, returned unchanged
// mem_re       out  1        memory read enable
// mem_addr     out  ADDR_W   word-aligned address (low log2(XLEN/8) bits zero)
// mem_rdata    in   XLEN     read data, valid the cycle after mem_re
// rsp_valid    out  1        response valid, held until rsp_ready
// rsp_ready    in   1        consumer accepts response
// rsp_data     out  XLEN     extended load result
// rsp_rd       out  5        tag of the response
// rsp_err      out  1        illegal funct3, or misaligned with MISALIGN_EN=0
// BEHAVIOUR
// - Reset: state=IDLE; rsp_valid, rsp_data, rsp_rd, rsp_err, mem_re = 0. Reset mid-load discards the load; no response.
// - Defined terms:
//   - W = XLEN/8 bytes; off = req_addr mod W; size = 1/2/4/8 bytes from funct3.
//   - Crossing = off + size > W.
// - Illegal funct3: 3'b011 and 3'b110 when XLEN=32; 3'b111 always.
// - FSM states: IDLE, BEAT0, BEAT1, RESP.
// - IDLE:
//   - req_ready=1.
//   - On req_valid with a legal, permitted request: mem_re=1 combinationally, mem_addr = aligned(req_addr). Latch addr/funct3/rd, go to BEAT0.
//   - Illegal or forbidden request: no memory access; load err response into RESP next cycle with rsp_data=0.
// - BEAT0:
//   - Capture mem_rdata into lo.
//   - If crossing: mem_re=1, mem_addr = aligned+W, go to BEAT1.
//   - Otherwise extract from lo, go to RESP.
// - BEAT1: capture mem_rdata as hi; extract from {hi,lo} shifted right by off bytes; go to RESP.
// - RESP: rsp_valid=1, outputs stable. On rsp_ready: go to IDLE, rsp_valid=0 next cycle. No request accepted while in RESP.
// - Latency from accept to rsp_valid: aligned 2 cycles, crossing 3, err 1.
// - Extension: signed ops replicate the MSB of the loaded field; LBU/LHU/LWU zero-fill. Result is truncated to XLEN.
// - Address arithmetic: aligned+W wraps modulo 2^ADDR_W; no err at wrap.
// - flush: in any state, return to IDLE next cycle with rsp_valid=0 and mem_re deasserted that cycle.
//   - A beat-1 read already issued is ignored.
//   - flush has priority over rsp_ready and over a same-cycle req_valid (request not accepted).
// - Simultaneous rsp_ready with RESP exit: req_ready is not asserted until the following IDLE cycle (no bypass).
// STRUCTURE
// - Package load_pkg:
//   - funct3 localparams (LB, LH, LW, LD, LBU, LHU, LWU);
//   - state enum load_state_e {IDLE, BEAT0, BEAT1, RESP};
//   - function load_size(funct3) returning a byte count;
//   - function load_is_signed(funct3).
// - Sub-module load_extract #(XLEN): combinational. Inputs {hi,lo}, off, funct3; output is the extended value. Reused by the store path's read-modify-write check.
// - Top level holds the FSM, latches, beat logic and response register.
// TESTING
// 1. XLEN=32, LW at 0x100, mem word 0x8899AABB -> mem_re at T, rsp_valid at T+2, rsp_data=0x8899AABB, err=0.
// 2. LB at 0x103, word 0x80112233 -> rsp_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
// 3. LW at 0x102, words 0x44332211 at 0x100 and 0x88776655 at 0x104 -> two reads (0x100, 0x104), rsp_data=0x66554433 at T+3.
// 4. LH at 0x103, MISALIGN_EN=0 -> no mem_re, rsp_err=1, rsp_data=0 at T+1; funct3=3'b111 -> same.
// 5. XLEN=64, LWU at 0x4, dword 0xFFFFFFFE_00000000 -> rsp_data=0x00000000_FFFFFFFE; LW at 0x4 -> 0xFFFFFFFF_FFFFFFFE.
// 6. Hold rsp_ready=0 for 5 cycles -> response stable; flush during BEAT1 -> no rsp_valid; rst_n low mid-BEAT0 -> all outputs 0, IDLE.

Source files
------------

// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load alignment unit: funct3 codes, FSM states
// and small decode helpers used by the top level and the extractor.
package load_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} load_state_e;

  // Byte count of the loaded field; the low two funct3 bits encode it.
  function automatic logic [3:0] load_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Signed loads have funct3[2] clear; LBU/LHU/LWU set it.
  function automatic logic load_is_signed(input logic [2:0] funct3);
    return !funct3[2];
  endfunction

  // 3'b111 is never a load; LD and LWU only exist on a 64-bit datapath.
  function automatic logic load_is_legal(input logic [2:0] funct3, input int xlen);
    if (funct3 == 3'b111) return 1'b0;
    if (xlen == 32 && (funct3 == LD || funct3 == LWU)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Request, memory-port and response signals of the load unit, bundled so the
// pipeline side (master) and the load unit (slave) see matching directions.
interface load_align_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [4:0]        req_rd;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_funct3, req_rd, mem_rdata, rsp_ready,
    input  req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_funct3, req_rd, mem_rdata, rsp_ready,
    output req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err
  );
endinterface

// File: rtl/load_align_unit_extract.sv
// Combinational load extractor: shifts a two-word window right by the byte
// offset, keeps the field selected by funct3 and sign- or zero-extends it.
module load_extract
  import load_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]         data,
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [2:0]                funct3,
  output logic [XLEN-1:0]           result
);

  logic [XLEN-1:0] low;
  logic [XLEN-1:0] mask;
  logic            sign;

  // Field mask and sign bit chosen by load size, then merged extension.
  always_comb begin
    low  = XLEN'(data >> {off, 3'b000});
    mask = '1;
    sign = low[XLEN-1];
    case (load_size(funct3))
      4'd1: begin mask = XLEN'(8'hFF);         sign = low[7];  end
      4'd2: begin mask = XLEN'(16'hFFFF);      sign = low[15]; end
      4'd4: begin mask = XLEN'(32'hFFFF_FFFF); sign = low[31]; end
      default: ;
    endcase
    result = (low & mask) | ((load_is_signed(funct3) && sign) ? ~mask : '0);
  end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load unit: issues one or two word-aligned reads per load,
// assembles misaligned fields and returns a registered, extended response.
module load_align_unit
  import load_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  load_align_unit_if.slave bus
);

  localparam int W     = XLEN / 8;
  localparam int OFF_W = $clog2(W);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic              rsp_err_q, rsp_err_d;

  logic [OFF_W-1:0]  req_off, cur_off;
  logic [3:0]        req_size, cur_size;
  logic              req_misaligned, req_ok, cur_cross;
  logic [ADDR_W-1:0] req_aligned, cur_aligned;
  logic [2*XLEN-1:0] ext_data;
  logic [XLEN-1:0]   ext_result;
  logic              mem_re_c;
  logic [ADDR_W-1:0] mem_addr_c;

  assign req_off        = bus.req_addr[OFF_W-1:0];
  assign req_size       = load_size(bus.req_funct3);
  assign req_misaligned = (4'(req_off) & (req_size - 4'd1)) != 4'd0;
  assign req_ok         = load_is_legal(bus.req_funct3, XLEN) && (MISALIGN_EN || !req_misaligned);
  assign req_aligned    = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign cur_off     = addr_q[OFF_W-1:0];
  assign cur_size    = load_size(funct3_q);
  assign cur_cross   = (5'(cur_off) + 5'(cur_size)) > 5'(W);
  assign cur_aligned = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign ext_data = (state_q == BEAT1) ? {bus.mem_rdata, lo_q} : {{XLEN{1'b0}}, bus.mem_rdata};

  load_extract #(.XLEN(XLEN)) u_extract (
    .data   (ext_data),
    .off    (cur_off),
    .funct3 (funct3_q),
    .result (ext_result)
  );

  // State, request latches and the response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      lo_q       <= '0;
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      lo_q       <= lo_d;
      rsp_data_q <= rsp_data_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next state, memory read issue and response loading; flush overrides all.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    lo_d       = lo_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;
    rsp_err_d  = rsp_err_q;
    mem_re_c   = 1'b0;
    mem_addr_c = cur_aligned;
    case (state_q)
      IDLE: begin
        mem_addr_c = req_aligned;
        if (bus.req_valid && !flush) begin
          if (req_ok) begin
            mem_re_c = 1'b1;
            addr_d   = bus.req_addr;
            funct3_d = bus.req_funct3;
            rd_d     = bus.req_rd;
            state_d  = BEAT0;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            rsp_rd_d   = bus.req_rd;
            state_d    = RESP;
          end
        end
      end
      BEAT0: begin
        mem_addr_c = cur_aligned + ADDR_W'(W);
        if (cur_cross) begin
          lo_d     = bus.mem_rdata;
          mem_re_c = 1'b1;
          state_d  = BEAT1;
        end else begin
          rsp_data_d = ext_result;
          rsp_err_d  = 1'b0;
          rsp_rd_d   = rd_q;
          state_d    = RESP;
        end
      end
      BEAT1: begin
        rsp_data_d = ext_result;
        rsp_err_d  = 1'b0;
        rsp_rd_d   = rd_q;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      mem_re_c = 1'b0;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_re    = mem_re_c & rst_n;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Testbench for load_align_unit: three instances (32-bit, 32-bit with
// misaligned loads refused, 64-bit) against a byte-addressed memory model.
module tb_load_align_unit;
  import load_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_valid, rsp_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  int          sel;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  load_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus_a ();
  load_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus_n ();
  load_align_unit_if #(.XLEN(64), .ADDR_W(32)) bus_w ();

  load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a.slave));
  load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_n.slave));
  load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_w.slave));

  assign bus_a.req_valid = req_valid && (sel == 0);
  assign bus_n.req_valid = req_valid && (sel == 1);
  assign bus_w.req_valid = req_valid && (sel == 2);
  assign bus_a.req_addr = req_addr;   assign bus_n.req_addr = req_addr;   assign bus_w.req_addr = req_addr;
  assign bus_a.req_funct3 = req_funct3; assign bus_n.req_funct3 = req_funct3; assign bus_w.req_funct3 = req_funct3;
  assign bus_a.req_rd = req_rd;       assign bus_n.req_rd = req_rd;       assign bus_w.req_rd = req_rd;
  assign bus_a.rsp_ready = rsp_ready; assign bus_n.rsp_ready = rsp_ready; assign bus_w.rsp_ready = rsp_ready;

  // Byte-addressed memory; only the low seven address bits select a byte.
  logic [7:0] mem_b [0:127];

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return mem_b[a[6:0]];
  endfunction

  function automatic logic [63:0] word_at(input logic [31:0] a, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++) r[8*i +: 8] = byte_at(a + 32'(i));
    return r;
  endfunction

  // One-cycle read latency memories, one per instance.
  always @(posedge clk) if (bus_a.mem_re) bus_a.mem_rdata <= 32'(word_at(bus_a.mem_addr, 4));
  always @(posedge clk) if (bus_n.mem_re) bus_n.mem_rdata <= 32'(word_at(bus_n.mem_addr, 4));
  always @(posedge clk) if (bus_w.mem_re) bus_w.mem_rdata <= word_at(bus_w.mem_addr, 8);

  logic        obs_req_ready, obs_mem_re, obs_rsp_valid, obs_rsp_err;
  logic [31:0] obs_mem_addr;
  logic [63:0] obs_rsp_data;
  logic [4:0]  obs_rsp_rd;

  // Outputs of the currently selected instance.
  always_comb begin
    case (sel)
      0: begin
        obs_req_ready = bus_a.req_ready; obs_mem_re = bus_a.mem_re; obs_mem_addr = bus_a.mem_addr;
        obs_rsp_valid = bus_a.rsp_valid; obs_rsp_err = bus_a.rsp_err;
        obs_rsp_data = 64'(bus_a.rsp_data); obs_rsp_rd = bus_a.rsp_rd;
      end
      1: begin
        obs_req_ready = bus_n.req_ready; obs_mem_re = bus_n.mem_re; obs_mem_addr = bus_n.mem_addr;
        obs_rsp_valid = bus_n.rsp_valid; obs_rsp_err = bus_n.rsp_err;
        obs_rsp_data = 64'(bus_n.rsp_data); obs_rsp_rd = bus_n.rsp_rd;
      end
      default: begin
        obs_req_ready = bus_w.req_ready; obs_mem_re = bus_w.mem_re; obs_mem_addr = bus_w.mem_addr;
        obs_rsp_valid = bus_w.rsp_valid; obs_rsp_err = bus_w.rsp_err;
        obs_rsp_data = bus_w.rsp_data; obs_rsp_rd = bus_w.rsp_rd;
      end
    endcase
  end

  // Log of read addresses issued by the selected instance.
  logic [31:0] rd_log [$];
  always @(posedge clk) if (obs_mem_re) rd_log.push_back(obs_mem_addr);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: assemble the field byte by byte from memory and extend it.
  task automatic model(input int s, input logic [31:0] a, input logic [2:0] f3,
                       output logic [63:0] d, output logic e, output int lat);
    int w  = (s == 2) ? 8 : 4;
    int sz = 1 << f3[1:0];
    int off = int'(a[2:0]) % w;
    logic legal = (f3 != 3'b111) && !(w == 4 && (f3 == 3'b011 || f3 == 3'b110));
    d = '0;
    e = !legal || (s == 1 && (int'(a[2:0]) % sz) != 0);
    lat = 1;
    if (e) return;
    for (int i = 0; i < sz; i++) d[8*i +: 8] = byte_at(a + 32'(i));
    if (!f3[2] && d[8*sz-1]) for (int i = 8*sz; i < 64; i++) d[i] = 1'b1;
    if (w == 4) d[63:32] = '0;
    lat = (off + sz > w) ? 3 : 2;
  endtask

  task automatic applyStimulus(input int s, input logic [31:0] a, input logic [2:0] f3,
                               input logic [4:0] rd, input int hold, input logic [63:0] exp_d,
                               input logic exp_e, input int exp_lat, input string tag);
    int w = (s == 2) ? 8 : 4;
    int lat;
    int nexp = exp_lat - 1;
    logic [31:0] al = a & ~32'(w - 1);
    @(negedge clk);
    sel = s;
    #1;
    checkOutput({tag, " req_ready idle"}, 64'(obs_req_ready), 64'd1);
    rd_log.delete();
    req_valid = 1'b1; req_addr = a; req_funct3 = f3; req_rd = rd; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!obs_rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
    if (!obs_rsp_valid) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      return;
    end
    checkOutput({tag, " data"}, obs_rsp_data, exp_d);
    checkOutput({tag, " err"}, 64'(obs_rsp_err), 64'(exp_e));
    checkOutput({tag, " rd"}, 64'(obs_rsp_rd), 64'(rd));
    checkOutput({tag, " read count"}, 64'(rd_log.size()), 64'(nexp));
    if (nexp > 0 && rd_log.size() > 0) checkOutput({tag, " read0 addr"}, 64'(rd_log[0]), 64'(al));
    if (nexp > 1 && rd_log.size() > 1) checkOutput({tag, " read1 addr"}, 64'(rd_log[1]), 64'(al + 32'(w)));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, " held valid"}, 64'(obs_rsp_valid), 64'd1);
      checkOutput({tag, " held data"}, obs_rsp_data, exp_d);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput({tag, " no bypass ready"}, 64'(obs_req_ready), 64'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, " valid drop"}, 64'(obs_rsp_valid), 64'd0);
    checkOutput({tag, " ready back"}, 64'(obs_req_ready), 64'd1);
  endtask

  typedef struct {
    int          s;
    logic [31:0] w0, w1, addr;
    logic [2:0]  f3;
    int          hold;
    logic [63:0] exp_d;
    logic        exp_e;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] md;
    logic        me;
    int          ml;
    logic [31:0] ra;
    logic [2:0]  rf;

    vecs[0]  = '{0, 32'h8899AABB, 32'h0,        32'h100, LW,     0, 64'h8899AABB,          1'b0, 2};
    vecs[1]  = '{0, 32'h80112233, 32'h0,        32'h103, LB,     0, 64'hFFFFFF80,          1'b0, 2};
    vecs[2]  = '{0, 32'h80112233, 32'h0,        32'h103, LBU,    0, 64'h00000080,          1'b0, 2};
    vecs[3]  = '{0, 32'h44332211, 32'h88776655, 32'h102, LW,     0, 64'h66554433,          1'b0, 3};
    vecs[4]  = '{1, 32'h44332211, 32'h88776655, 32'h103, LH,     0, 64'h0,                 1'b1, 1};
    vecs[5]  = '{1, 32'h44332211, 32'h88776655, 32'h100, 3'b111, 0, 64'h0,                 1'b1, 1};
    vecs[6]  = '{2, 32'h00000000, 32'hFFFFFFFE, 32'h004, LWU,    0, 64'h00000000FFFFFFFE,  1'b0, 2};
    vecs[7]  = '{2, 32'h00000000, 32'hFFFFFFFE, 32'h004, LW,     0, 64'hFFFFFFFFFFFFFFFE,  1'b0, 2};
    vecs[8]  = '{0, 32'h8899AABB, 32'h0,        32'h100, LW,     5, 64'h8899AABB,          1'b0, 2};
    vecs[9]  = '{0, 32'h44332211, 32'h88776655, 32'h101, LH,     0, 64'h3322,              1'b0, 2};
    vecs[10] = '{0, 32'h44332211, 32'h88776655, 32'h103, LH,     1, 64'h5544,              1'b0, 3};
    vecs[11] = '{0, 32'h44332211, 32'h88776655, 32'h106, LH,     0, 64'hFFFF8877,          1'b0, 2};
    vecs[12] = '{0, 32'h44332211, 32'h88776655, 32'h100, 3'b011, 0, 64'h0,                 1'b1, 1};
    vecs[13] = '{2, 32'h44332211, 32'h88776655, 32'h000, LD,     0, 64'h8877665544332211,  1'b0, 2};
    vecs[14] = '{1, 32'h8899AABB, 32'h0,        32'h100, LW,     0, 64'h8899AABB,          1'b0, 2};
    vecs[15] = '{2, 32'h44332211, 32'h88776655, 32'h008, 3'b111, 0, 64'h0,                 1'b1, 1};

    for (int i = 0; i < 128; i++) mem_b[i] = 8'h00;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_funct3 = '0; req_rd = '0; sel = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput($sformatf("reset%0d valid", s), 64'(obs_rsp_valid), 64'd0);
      checkOutput($sformatf("reset%0d data", s), obs_rsp_data, 64'd0);
      checkOutput($sformatf("reset%0d err", s), 64'(obs_rsp_err), 64'd0);
      checkOutput($sformatf("reset%0d rd", s), 64'(obs_rsp_rd), 64'd0);
      checkOutput($sformatf("reset%0d mem_re", s), 64'(obs_mem_re), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 4; b++) begin
        mem_b[b]     = vecs[i].w0[8*b +: 8];
        mem_b[4 + b] = vecs[i].w1[8*b +: 8];
      end
      applyStimulus(vecs[i].s, vecs[i].addr, vecs[i].f3, 5'(i + 1), vecs[i].hold,
                    vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Flush while the second beat is outstanding: no response may appear.
    @(negedge clk); sel = 0;
    req_valid = 1'b1; req_addr = 32'h102; req_funct3 = LW; req_rd = 5'd7;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); flush = 1'b1;
    #1 checkOutput("flush beat1 mem_re", 64'(obs_mem_re), 64'd0);
    @(negedge clk); flush = 1'b0;
    checkOutput("flush beat1 ready", 64'(obs_req_ready), 64'd1);
    repeat (3) begin
      checkOutput("flush beat1 no valid", 64'(obs_rsp_valid), 64'd0);
      @(negedge clk);
    end

    // Flush in BEAT0 of a crossing load suppresses the second read.
    req_valid = 1'b1; req_addr = 32'h103; req_funct3 = LH; req_rd = 5'd8;
    @(negedge clk); req_valid = 1'b0; flush = 1'b1;
    #1 checkOutput("flush beat0 mem_re", 64'(obs_mem_re), 64'd0);
    @(negedge clk); flush = 1'b0;
    checkOutput("flush beat0 ready", 64'(obs_req_ready), 64'd1);
    checkOutput("flush beat0 no valid", 64'(obs_rsp_valid), 64'd0);

    // Flush beats a same-cycle request.
    req_valid = 1'b1; req_addr = 32'h100; req_funct3 = LW; req_rd = 5'd9; flush = 1'b1;
    #1 checkOutput("flush idle mem_re", 64'(obs_mem_re), 64'd0);
    @(negedge clk); req_valid = 1'b0; flush = 1'b0;
    checkOutput("flush idle not taken", 64'(obs_req_ready), 64'd1);
    @(negedge clk);
    checkOutput("flush idle no valid", 64'(obs_rsp_valid), 64'd0);

    // Flush beats rsp_ready while holding a response.
    req_valid = 1'b1; req_addr = 32'h100; req_funct3 = LW; req_rd = 5'd10;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush resp valid", 64'(obs_rsp_valid), 64'd1);
    flush = 1'b1; rsp_ready = 1'b1;
    @(negedge clk); flush = 1'b0; rsp_ready = 1'b0;
    checkOutput("flush resp dropped", 64'(obs_rsp_valid), 64'd0);
    checkOutput("flush resp ready", 64'(obs_req_ready), 64'd1);

    // Reset in the middle of BEAT0 clears the response register.
    for (int i = 0; i < 8; i++) mem_b[i] = 8'(8'hA0 + i);
    applyStimulus(0, 32'h100, LW, 5'd11, 0, 64'hA3A2A1A0, 1'b0, 2, "pre-reset");
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h104; req_funct3 = LW; req_rd = 5'd12;
    @(negedge clk); req_valid = 1'b0; rst_n = 1'b0;
    #1;
    checkOutput("midreset valid", 64'(obs_rsp_valid), 64'd0);
    checkOutput("midreset data", obs_rsp_data, 64'd0);
    checkOutput("midreset rd", 64'(obs_rsp_rd), 64'd0);
    checkOutput("midreset err", 64'(obs_rsp_err), 64'd0);
    checkOutput("midreset mem_re", 64'(obs_mem_re), 64'd0);
    checkOutput("midreset idle", 64'(obs_req_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("postreset no valid", 64'(obs_rsp_valid), 64'd0);
    end

    // Randomised loads across all three instances, including address wrap.
    for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom);
    for (int n = 0; n < 150; n++) begin
      int s = $urandom_range(0, 2);
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      rf = 3'($urandom_range(0, 7));
      model(s, ra, rf, md, me, ml);
      applyStimulus(s, ra, rf, 5'($urandom_range(0, 31)), $urandom_range(0, 2),
                    md, me, ml, $sformatf("rnd%0d s%0d a%0h f%0d", n, s, ra, rf));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
